// File: rtl/rng_draw_arbiter.sv
// Round-robin arbiter sharing one 3-bit LFSR among NUM_REQ consumers.
// Each draw steps the RNG exactly STEP_CYCLES times, then returns the value with a one-cycle grant.
module rng_draw_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int STEP_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               stir_en,
    input  logic [2:0]         rng_num,
    output logic               rng_gen,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         rand_out,
    output logic [ID_W-1:0]    draw_id,
    output logic               busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        LOAD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         step_cnt_q, step_cnt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    winner_q, winner_d;
    logic               rng_gen_q, rng_gen_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]         rand_q, rand_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               busy_q, busy_d;

    logic [ID_W-1:0]    pick;
    logic               pick_vld;

    // First set request at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_vld && req[IDX_W'(idx)]) begin
                pick_vld = 1'b1;
                pick     = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        winner_d   = winner_q;
        rng_gen_d  = rng_gen_q;
        gnt_d      = gnt_q;
        rand_d     = rand_q;
        id_d       = id_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    winner_d   = pick;
                    step_cnt_d = '0;
                    rng_gen_d  = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = STEP;
                end else begin
                    rng_gen_d  = stir_en;
                end
            end
            STEP: begin
                step_cnt_d = step_cnt_q + 8'd1;
                // Drop rng_gen on the edge where the count reaches STEP_CYCLES.
                if (step_cnt_q == 8'(STEP_CYCLES - 1)) begin
                    rng_gen_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                rand_d  = rng_num;
                id_d    = winner_q;
                gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_q;
                if (int'(winner_q) == NUM_REQ - 1) rr_ptr_d = '0;
                else                               rr_ptr_d = winner_q + 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // Guard cycle: req is ignored so the winner can drop it as gnt ends.
                gnt_d     = '0;
                busy_d    = 1'b0;
                rng_gen_d = stir_en;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            rng_gen_q  <= 1'b0;
            gnt_q      <= '0;
            rand_q     <= '0;
            id_q       <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            winner_q   <= winner_d;
            rng_gen_q  <= rng_gen_d;
            gnt_q      <= gnt_d;
            rand_q     <= rand_d;
            id_q       <= id_d;
            busy_q     <= busy_d;
        end
    end

    assign rng_gen  = rng_gen_q;
    assign gnt      = gnt_q;
    assign rand_out = rand_q;
    assign draw_id  = id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_rng_draw_arbiter.sv
// Bench for rng_draw_arbiter: RNG modelled as a 3-bit counter stepped by rng_gen,
// directed scenarios followed by randomized draws checked against a round-robin model.
module tb_rng_draw_arbiter;

    localparam int NREQ = 4;
    localparam int STEPS = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req;
    logic            stir_en;
    logic [2:0]      rng_num;
    logic            rng_gen;
    logic [NREQ-1:0] gnt;
    logic [2:0]      rand_out;
    logic [1:0]      draw_id;
    logic            busy;

    logic [2:0]      cnt;
    int              total = 0;
    int              bad = 0;
    int              m_ptr = 0;

    rng_draw_arbiter #(.NUM_REQ(NREQ), .ID_W(2), .STEP_CYCLES(STEPS)) dut (
        .clk(clk), .rst(rst), .req(req), .stir_en(stir_en), .rng_num(rng_num),
        .rng_gen(rng_gen), .gnt(gnt), .rand_out(rand_out), .draw_id(draw_id), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst)          cnt <= 3'd0;
        else if (rng_gen) cnt <= cnt + 3'd1;
    end
    assign rng_num = cnt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r);
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (m_ptr + i) % NREQ;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1; req = '0; stir_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_ptr = 0;
    endtask

    // One complete draw starting from IDLE; returns the DUT's reported id and value.
    task automatic draw(input logic [3:0] r, input logic st, input bit noisy,
                        output int oid, output int oval);
        int         w;
        logic [2:0] c0;
        logic [2:0] ev;
        logic       st5;
        w = model_pick(r);
        req = r; stir_en = st;
        tick();
        c0 = cnt;
        ev = c0 + 3'd3;
        chk("start_busy", busy, 1);
        chk("start_gen", rng_gen, 1);
        for (int k = 1; k <= STEPS; k++) begin
            if (noisy) begin req = 4'($urandom); stir_en = 1'($urandom); end
            tick();
            chk("step_gen", rng_gen, (k < STEPS) ? 1 : 0);
            chk("step_gnt", gnt, 0);
        end
        chk("load_cnt", cnt, ev);
        if (noisy) begin req = 4'($urandom); stir_en = 1'($urandom); end
        tick();
        chk("gnt_onehot", gnt, 32'd1 << w);
        chk("gnt_rand", rand_out, ev);
        chk("gnt_id", draw_id, w);
        chk("gnt_busy", busy, 1);
        chk("gnt_gen", rng_gen, 0);
        chk("gnt_cnt", cnt, ev);
        oid = int'(draw_id);
        oval = int'(rand_out);
        st5 = noisy ? 1'($urandom) : st;
        stir_en = st5;
        tick();
        chk("done_gnt", gnt, 0);
        chk("done_busy", busy, 0);
        chk("done_gen", rng_gen, st5);
        req = '0;
        m_ptr = (w + 1) % NREQ;
    endtask

    initial begin
        int id, v;
        int exp_id[5];
        int exp_v[5];
        exp_id = '{0, 1, 2, 3, 0};
        exp_v  = '{3, 6, 1, 4, 7};

        // Reset
        do_reset();
        chk("rst_gen", rng_gen, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_rand", rand_out, 0);
        chk("rst_id", draw_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", cnt, 0);
        tick();
        tick();
        chk("idle_gen", rng_gen, 0);
        chk("idle_cnt", cnt, 0);

        // Single draw
        do_reset();
        draw(4'b0100, 1'b0, 1'b0, id, v);
        chk("single_id", id, 2);
        chk("single_val", v, 3);

        // Fairness, back-to-back
        do_reset();
        for (int n = 0; n < 5; n++) begin
            draw(4'b1111, 1'b0, 1'b0, id, v);
            chk("fair_id", id, exp_id[n]);
            chk("fair_val", v, exp_v[n]);
        end

        // Pointer continues from winner+1
        do_reset();
        draw(4'b0010, 1'b0, 1'b0, id, v);
        chk("ptr_first", id, 1);
        draw(4'b1001, 1'b0, 1'b0, id, v);
        chk("ptr_second", id, 3);
        draw(4'b1001, 1'b0, 1'b0, id, v);
        chk("ptr_third", id, 0);

        // Reset mid-draw
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_gen", rng_gen, 0);
        chk("mid_busy", busy, 0);
        chk("mid_gnt", gnt, 0);
        rst = 1'b0; req = '0; m_ptr = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid_nognt", gnt, 0);
        end
        draw(4'b0011, 1'b0, 1'b0, id, v);
        chk("mid_after", id, 0);

        // Stir
        do_reset();
        stir_en = 1'b1;
        tick();
        chk("stir_on", rng_gen, 1);
        chk("stir_cnt0", cnt, 0);
        for (int k = 0; k < 9; k++) tick();
        chk("stir_gen", rng_gen, 1);
        chk("stir_cnt", cnt, 1);
        stir_en = 1'b0;
        tick();
        chk("stir_off", rng_gen, 0);
        chk("stir_cnt_a", cnt, 2);
        tick();
        chk("stir_cnt_b", cnt, 2);
        draw(4'b0001, 1'b1, 1'b0, id, v);
        chk("stir_draw_id", id, 0);

        // Randomized draws with idle gaps, stir and req noise
        do_reset();
        for (int n = 0; n < 25; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                logic s;
                s = 1'($urandom);
                stir_en = s; req = '0;
                tick();
                chk("gap_gen", rng_gen, s);
                chk("gap_gnt", gnt, 0);
                chk("gap_busy", busy, 0);
            end
            draw(4'($urandom_range(1, 15)), 1'($urandom), 1'b1, id, v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_draw_arbiter.md
Name: rng_draw_arbiter

Overview:
Shares the single 3-bit LFSR random-number source among up to NUM_REQ consumers, such as the per-lane object shifters that need a random spawn position. The arbiter grants requesters in round-robin order. For each draw it steps the RNG exactly STEP_CYCLES times, then returns the captured 3-bit value together with a one-cycle grant to the winner. Between draws it can optionally keep the RNG running ("stir") so that draw results depend on player timing.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of draw_id; must satisfy 2**ID_W >= NUM_REQ
STEP_CYCLES, 3, RNG advances per draw (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  level request per requester; held until its gnt bit is seen
stir_en  in  1  when high, the RNG free-runs while the arbiter is idle
rng_num  in  3  current RNG output (combinational from the RNG state register)
rng_gen  out  1  RNG advance enable; registered
gnt  out  NUM_REQ  one-hot, one-cycle grant; rand_out is valid while gnt is high
rand_out  out  3  captured random value; holds until the next capture
draw_id  out  ID_W  index of the granted requester; holds until the next capture
busy  out  1  high while a draw is in progress (STEP, LOAD, DONE)

Behaviour:
- Reset (rst=1 at a clk edge) forces the following, regardless of the current state:
  - state=IDLE, rng_gen=0, gnt=0, rand_out=0, draw_id=0, busy=0, step_cnt=0, rr_ptr=0.
  - A draw in flight is abandoned and no gnt is issued.
- State machine: IDLE -> STEP -> LOAD -> DONE -> IDLE.
- IDLE:
  - If any req bit is set, select the winner: search from rr_ptr upward, modulo NUM_REQ; the first set bit wins.
  - On a win: latch the winner, clear step_cnt, and go to STEP. rng_gen<=1 and busy<=1.
  - With no request, stay in IDLE with rng_gen<=stir_en. Stir advances carry no count guarantee.
- STEP:
  - Each edge increments step_cnt.
  - When step_cnt reaches STEP_CYCLES: rng_gen<=0 and go to LOAD.
  - Result: rng_gen is high for exactly STEP_CYCLES consecutive cycles, so the RNG advances exactly STEP_CYCLES times per draw.
- LOAD (one cycle):
  - rand_out<=rng_num, draw_id<=winner, gnt<=onehot(winner).
  - rr_ptr<=(winner+1) mod NUM_REQ; go to DONE.
- DONE (one cycle, gnt high):
  - req is not sampled. This guard cycle lets the requester drop req at the edge that ends the gnt cycle.
  - gnt<=0, busy<=0, go to IDLE. rng_gen<=stir_en.
- Latency: the request is sampled at edge E0 and gnt is high in the cycle after edge E(STEP_CYCLES+1). Throughput is one draw per STEP_CYCLES+3 cycles.
- A requester that drops req after winning still completes its draw: its gnt still pulses and rr_ptr still advances.
- Changes to req during STEP, LOAD or DONE have no effect on the draw in progress.
- stir_en is ignored outside IDLE.
- rand_out and draw_id change only in LOAD or on reset.
- Requester indices >= NUM_REQ are never granted.

Test Plan:
In all scenarios the bench models the RNG as a 3-bit counter that increments on every edge where rng_gen=1, starting at 0 after reset.

1. Reset: rst=1 for 2 cycles, then 0, with req=0 and stir_en=0 -> rng_gen, gnt, rand_out, draw_id and busy are all 0; the counter stays at 0.
2. Single draw: stir_en=0, req=4'b0100 from cycle 0 -> rng_gen high for exactly 3 cycles; gnt=4'b0100 for one cycle after edge E4; rand_out=3'd3; draw_id=2; busy is high from E1 through the gnt cycle.
3. Fairness: req=4'b1111 held continuously (bench drops and re-raises each bit around its grant) -> grants go to 0,1,2,3,0, spaced 6 cycles apart; rand_out takes the values 3, 6, 1, 4, 7.
4. Pointer: after a grant to requester 1 (rr_ptr=2), raise req=4'b1001 -> requester 3 is granted, then requester 0.
5. Reset mid-draw: req[0] is asserted and rst=1 on the second STEP cycle -> the next cycle shows state IDLE with rng_gen=0 and busy=0; gnt is never asserted; after rst is released, req=4'b0011 grants requester 0 first.
6. Stir: stir_en=1 with no req for 10 cycles -> rng_gen is high from the cycle after stir_en is first sampled; stir_en=0 then stops the counter within one cycle; during a subsequent draw the counter advances exactly 3 regardless of stir_en.
